// File: rtl/hls_deadlock_param_monitor.sv
// Dataflow deadlock monitor: derives a raw "all stopped, one on a stream" condition,
// debounces it into a sticky deadlock flag with irq pulse and stuck-stream snapshot.
module hls_deadlock_param_monitor #(
  parameter int unsigned NUM_PROC = 3,
  parameter int unsigned NUM_AXIS = 12,
  parameter int unsigned THRESH_W = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_AXIS-1:0]          axis_block_sigs,
  input  logic [NUM_PROC-1:0]          inst_idle_sigs,
  input  logic [NUM_PROC-1:0]          inst_block_sigs,
  input  logic [NUM_PROC-1:0]          child_block,
  input  logic [NUM_PROC*NUM_AXIS-1:0] axis_map,
  input  logic [THRESH_W-1:0]          threshold,
  input  logic                         enable,
  input  logic                         clear,
  output logic                         block,
  output logic                         deadlock,
  output logic                         irq,
  output logic [CNT_W-1:0]             stall_cnt,
  output logic [CNT_W-1:0]             suspect_cnt,
  output logic [NUM_AXIS-1:0]          snap_axis,
  output logic [NUM_PROC-1:0]          snap_proc
);

  localparam int unsigned CMP_W = ((CNT_W > THRESH_W) ? CNT_W : THRESH_W) + 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_SUSPECT,
    ST_LOCKED
  } state_t;

  state_t state;

  logic [NUM_PROC-1:0] axis_blk;
  logic [NUM_PROC-1:0] stop;
  logic [NUM_AXIS-1:0] snap_or;
  logic                cond;

  // Per-process stream block, stop, and union of streams owned by stream-blocked processes
  always_comb begin
    axis_blk = '0;
    stop     = '0;
    snap_or  = '0;
    for (int p = 0; p < int'(NUM_PROC); p++) begin
      axis_blk[p] = child_block[p] & (|(axis_block_sigs & axis_map[p*NUM_AXIS +: NUM_AXIS]));
      stop[p]     = inst_idle_sigs[p] | inst_block_sigs[p] | axis_blk[p];
      snap_or     = snap_or | (axis_map[p*NUM_AXIS +: NUM_AXIS] & {NUM_AXIS{axis_blk[p]}});
    end
    cond = (|axis_blk) & (&stop);
  end

  logic [THRESH_W-1:0] teff;
  logic                teff_is_one;
  logic                reach_thresh;
  logic [CNT_W-1:0]    stall_inc;
  logic [CNT_W-1:0]    suspect_inc;

  // Threshold of zero behaves as one; counters saturate instead of wrapping
  always_comb begin
    teff         = (threshold == '0) ? THRESH_W'(1) : threshold;
    teff_is_one  = (teff == THRESH_W'(1));
    reach_thresh = (CMP_W'(stall_cnt) + CMP_W'(1)) >= CMP_W'(teff);
    stall_inc    = (stall_cnt == '1) ? stall_cnt : stall_cnt + CNT_W'(1);
    suspect_inc  = (suspect_cnt == '1) ? suspect_cnt : suspect_cnt + CNT_W'(1);
  end

  // Raw condition register, unaffected by enable and clear
  always_ff @(posedge clock) begin
    if (reset) begin
      block <= 1'b0;
    end else begin
      block <= cond;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_RUN;
      deadlock    <= 1'b0;
      irq         <= 1'b0;
      stall_cnt   <= '0;
      suspect_cnt <= '0;
      snap_axis   <= '0;
      snap_proc   <= '0;
    end else if (clear) begin
      state       <= ST_RUN;
      deadlock    <= 1'b0;
      irq         <= 1'b0;
      stall_cnt   <= '0;
      suspect_cnt <= '0;
      snap_axis   <= '0;
      snap_proc   <= '0;
    end else begin
      irq <= 1'b0;
      case (state)
        ST_RUN: begin
          stall_cnt <= '0;
          if (enable && cond) begin
            stall_cnt   <= CNT_W'(1);
            suspect_cnt <= suspect_inc;
            if (teff_is_one) begin
              state     <= ST_LOCKED;
              deadlock  <= 1'b1;
              irq       <= 1'b1;
              snap_axis <= axis_block_sigs & snap_or;
              snap_proc <= axis_blk;
            end else begin
              state <= ST_SUSPECT;
            end
          end
        end
        ST_SUSPECT: begin
          if (!enable || !cond) begin
            state     <= ST_RUN;
            stall_cnt <= '0;
          end else begin
            stall_cnt <= stall_inc;
            if (reach_thresh) begin
              state     <= ST_LOCKED;
              deadlock  <= 1'b1;
              irq       <= 1'b1;
              snap_axis <= axis_block_sigs & snap_or;
              snap_proc <= axis_blk;
            end
          end
        end
        ST_LOCKED: begin
          deadlock <= 1'b1;
          if (cond) begin
            stall_cnt <= stall_inc;
          end
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hls_deadlock_param_monitor.sv
// Directed bench for hls_deadlock_param_monitor with hand-computed expectations.
module tb_hls_deadlock_param_monitor;

  localparam int unsigned NUM_PROC = 3;
  localparam int unsigned NUM_AXIS = 12;
  localparam int unsigned THRESH_W = 16;
  localparam int unsigned CNT_W    = 32;

  logic                         clock = 1'b0;
  logic                         reset;
  logic [NUM_AXIS-1:0]          axis_block_sigs;
  logic [NUM_PROC-1:0]          inst_idle_sigs;
  logic [NUM_PROC-1:0]          inst_block_sigs;
  logic [NUM_PROC-1:0]          child_block;
  logic [NUM_PROC*NUM_AXIS-1:0] axis_map;
  logic [THRESH_W-1:0]          threshold;
  logic                         enable;
  logic                         clear;
  logic                         block;
  logic                         deadlock;
  logic                         irq;
  logic [CNT_W-1:0]             stall_cnt;
  logic [CNT_W-1:0]             suspect_cnt;
  logic [NUM_AXIS-1:0]          snap_axis;
  logic [NUM_PROC-1:0]          snap_proc;

  int total = 0;
  int bad   = 0;

  hls_deadlock_param_monitor #(
    .NUM_PROC(NUM_PROC), .NUM_AXIS(NUM_AXIS), .THRESH_W(THRESH_W), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset),
    .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
    .inst_block_sigs(inst_block_sigs), .child_block(child_block),
    .axis_map(axis_map), .threshold(threshold), .enable(enable), .clear(clear),
    .block(block), .deadlock(deadlock), .irq(irq), .stall_cnt(stall_cnt),
    .suspect_cnt(suspect_cnt), .snap_axis(snap_axis), .snap_proc(snap_proc)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic b, input logic d, input logic i,
                         input logic [31:0] sc, input logic [31:0] su);
    chk({tag, ".block"}, 64'(block), 64'(b));
    chk({tag, ".deadlock"}, 64'(deadlock), 64'(d));
    chk({tag, ".irq"}, 64'(irq), 64'(i));
    chk({tag, ".stall"}, 64'(stall_cnt), 64'(sc));
    chk({tag, ".suspect"}, 64'(suspect_cnt), 64'(su));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; enable = 1'b1; threshold = 16'd4;
    axis_block_sigs = '0; inst_idle_sigs = '0; inst_block_sigs = '0;
    child_block = 3'b111;
    axis_map = '0;
    axis_map[3:0]   = 4'hf;
    axis_map[22:16] = 7'h7f;
    axis_map[35]    = 1'b1;
    tick(); tick();
    chk_all("reset", 1'b0, 1'b0, 1'b0, 0, 0);
    chk("reset.snap_axis", 64'(snap_axis), 64'h0);
    chk("reset.snap_proc", 64'(snap_proc), 64'h0);
    reset = 1'b0;

    // 1: stream 2 of p0 blocked, p1/p2 idle, threshold 4
    inst_idle_sigs = 3'b110; axis_block_sigs = 12'h004;
    tick(); chk_all("t1.e0", 1'b1, 1'b0, 1'b0, 1, 1);
    tick(); chk_all("t1.e1", 1'b1, 1'b0, 1'b0, 2, 1);
    tick(); chk_all("t1.e2", 1'b1, 1'b0, 1'b0, 3, 1);
    tick(); chk_all("t1.e3", 1'b1, 1'b1, 1'b1, 4, 1);
    chk("t1.snap_axis", 64'(snap_axis), 64'h004);
    chk("t1.snap_proc", 64'(snap_proc), 64'h1);
    tick(); chk_all("t1.e4", 1'b1, 1'b1, 1'b0, 5, 1);

    // 2: bursts of 3 separated by a 1-cycle gap never lock
    axis_block_sigs = '0;
    do_clear();
    chk_all("t2.clr", 1'b0, 1'b0, 1'b0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      axis_block_sigs = 12'h004;
      for (int c = 1; c <= 3; c++) begin
        tick();
        chk_all($sformatf("t2.r%0d.c%0d", r, c), 1'b1, 1'b0, 1'b0, 32'(c), 32'(r + 1));
      end
      axis_block_sigs = '0;
      tick();
      chk_all($sformatf("t2.r%0d.gap", r), 1'b0, 1'b0, 1'b0, 0, 32'(r + 1));
    end

    // 3: threshold 0 behaves as 1
    threshold = 16'd0;
    do_clear();
    axis_block_sigs = 12'h004;
    tick(); chk_all("t3.lock", 1'b1, 1'b1, 1'b1, 1, 1);

    // 4: locked with cond dropped holds; clear with cond high wins
    axis_block_sigs = '0;
    tick(); chk_all("t4.hold0", 1'b0, 1'b1, 1'b0, 1, 1);
    tick(); chk_all("t4.hold1", 1'b0, 1'b1, 1'b0, 1, 1);
    axis_block_sigs = 12'h004; threshold = 16'd4;
    do_clear();
    chk_all("t4.clr", 1'b1, 1'b0, 1'b0, 0, 0);
    chk("t4.clr.snap_axis", 64'(snap_axis), 64'h0);
    chk("t4.clr.snap_proc", 64'(snap_proc), 64'h0);
    tick(); chk_all("t4.susp", 1'b1, 1'b0, 1'b0, 1, 1);

    // 5: nested monitor masks stream block of p0
    axis_block_sigs = '0;
    do_clear();
    child_block = 3'b110; axis_block_sigs = 12'h004;
    tick(); chk_all("t5.mask0", 1'b0, 1'b0, 1'b0, 0, 0);
    tick(); chk_all("t5.mask1", 1'b0, 1'b0, 1'b0, 0, 0);
    child_block = 3'b111;
    tick(); chk("t5.unmask.block", 64'(block), 64'h1);
    // a running process (p1 not idle) keeps cond low
    axis_block_sigs = '0; inst_idle_sigs = 3'b100;
    do_clear();
    axis_block_sigs = 12'h004;
    tick(); chk_all("t5.run", 1'b0, 1'b0, 1'b0, 0, 0);

    // 6: disabled monitor never suspects
    axis_block_sigs = '0; inst_idle_sigs = 3'b110; enable = 1'b0;
    do_clear();
    axis_block_sigs = 12'h004;
    for (int c = 0; c < 100; c++) begin
      tick();
      chk($sformatf("t6.blk%0d", c), 64'(block), 64'h1);
      chk($sformatf("t6.dl%0d", c), 64'(deadlock), 64'h0);
    end
    chk_all("t6.end", 1'b1, 1'b0, 1'b0, 0, 0);

    // multi-process snapshot, p2 masked by its child monitor
    enable = 1'b1; threshold = 16'd1;
    child_block = 3'b011; inst_idle_sigs = 3'b100; axis_block_sigs = 12'h814;
    tick(); chk_all("t6.lock", 1'b1, 1'b1, 1'b1, 1, 1);
    chk("t6.snap_axis", 64'(snap_axis), 64'h014);
    chk("t6.snap_proc", 64'(snap_proc), 64'h3);
    tick(); chk_all("t6.locked", 1'b1, 1'b1, 1'b0, 2, 1);
    reset = 1'b1;
    tick(); chk_all("t6.rst", 1'b0, 1'b0, 1'b0, 0, 0);
    chk("t6.rst.snap_axis", 64'(snap_axis), 64'h0);
    chk("t6.rst.snap_proc", 64'(snap_proc), 64'h0);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hls_deadlock_param_monitor.md
Name: hls_deadlock_param_monitor

Overview:
Parametrised dataflow deadlock monitor for HLS-generated regions such as the cyt_rdma dataflow instance. Per cycle it derives a raw "all processes stopped, at least one on an AXI-Stream" condition from per-process idle/channel-block/stream-block signals and a runtime stream-to-process map. A persistence counter debounces the condition into a sticky deadlock flag, which also raises an interrupt pulse and captures which streams and processes were stuck. Nested monitors feed their block outputs in through child_block.

Parameters:
NUM_PROC, 3, number of dataflow processes monitored
NUM_AXIS, 12, number of AXI-Stream block signals
THRESH_W, 16, width of threshold input
CNT_W, 32, width of stall and event counters

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
axis_block_sigs  in  NUM_AXIS  per-stream blocked flag
inst_idle_sigs  in  NUM_PROC  per-process idle
inst_block_sigs  in  NUM_PROC  per-process channel (FIFO/PIPO) blocked
child_block  in  NUM_PROC  block output of nested monitor for process p; tie 1 when none
axis_map  in  NUM_PROC*NUM_AXIS  bit [p*NUM_AXIS+a] = stream a belongs to process p; quasi-static
threshold  in  THRESH_W  consecutive cycles required for deadlock; 0 treated as 1
enable  in  1  arms debounce FSM
clear  in  1  clears sticky state, counters, snapshots
block  out  1  registered raw condition (1-cycle latency)
deadlock  out  1  sticky deadlock flag
irq  out  1  one-cycle pulse on entry to LOCKED
stall_cnt  out  CNT_W  consecutive condition cycles, saturating
suspect_cnt  out  CNT_W  number of RUN->SUSPECT entries, saturating
snap_axis  out  NUM_AXIS  streams blocked at lock edge
snap_proc  out  NUM_PROC  processes stream-blocked at lock edge

Behaviour:
- Combinational, per process p:
  - axis_blk[p] = child_block[p] & |(axis_block_sigs & axis_map[p]).
  - stop[p] = inst_idle_sigs[p] | inst_block_sigs[p] | axis_blk[p].
  - cond = (|axis_blk) & (&stop).
- block <= cond every cycle. Independent of enable and clear; reset only.
- Reset: all outputs 0, state RUN.
- Priority: reset > clear > FSM. clear returns to RUN and zeroes stall_cnt, snap_*, deadlock and irq. suspect_cnt is also zeroed.
- Effective threshold: Teff = max(threshold, 1), sampled every cycle.
- FSM states:
  - RUN:
    - enable & cond -> SUSPECT; stall_cnt <= 1; suspect_cnt++.
    - If Teff == 1, go directly to LOCKED instead; still stall_cnt <= 1 and suspect_cnt++.
    - Otherwise stall_cnt <= 0.
  - SUSPECT:
    - !enable or !cond -> RUN; stall_cnt <= 0.
    - Else stall_cnt++. If stall_cnt+1 >= Teff -> LOCKED.
  - LOCKED:
    - deadlock = 1.
    - stall_cnt++ while cond, holds while !cond.
    - Ignores enable. Exits only on clear or reset.
- Lock edge (any transition into LOCKED):
  - irq <= 1 for exactly one cycle.
  - snap_axis <= axis_block_sigs & OR over p of (axis_map[p] masked by axis_blk[p]).
  - snap_proc <= axis_blk.
- Deadlock is first visible Teff cycles after the first cycle cond was high, i.e. the same edge at which stall_cnt becomes Teff.
- Counters saturate at all-ones and do not wrap.
- A process with zero map bits can never be stream-blocked; it still contributes stop via idle or channel block.
- clear and cond high on the same edge: clear wins. The FSM re-evaluates cond on the next edge.

Test Plan:
1. Defaults, map p0={0..3}, p1={4..10}, p2={11}, child=3'b111, threshold=4, enable=1. Drive idle=3'b110, axis[2]=1 held → block=1 one cycle later; deadlock and irq rise 4 cycles after the first cond cycle; stall_cnt=4, snap_axis=12'h004, snap_proc=3'b001, suspect_cnt=1.
2. Same setup, cond high for 3 cycles, low 1 cycle, high 3 cycles → deadlock never rises, suspect_cnt=2, stall_cnt returns to 0 at each gap.
3. threshold=0 → cond for 1 cycle gives deadlock=1, irq single pulse, stall_cnt=1.
4. Locked, cond drops → deadlock stays 1, stall_cnt freezes. Then clear with cond high on the same edge → all zeroed, RUN; SUSPECT is entered on the next edge.
5. child_block[0]=0 with axis[2] blocked and all others idle → cond=0, block stays 0. Set child_block[0]=1 → block=1 next cycle.
6. enable=0 with cond held 100 cycles → block=1 throughout, deadlock=0, suspect_cnt=0. Then reset mid-LOCKED → all outputs 0 the next cycle.
